// File: rtl/latency_return_buffer_if.sv
// Bundle between a fixed-latency delay pipe, its producer, the result buffer and its consumer.
// Latency: none; this file only groups the wires.
// Backpressure: out_ready from the consumer; the producer is throttled by can_issue.
interface latency_return_buffer_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             issue;
  logic             can_issue;
  logic             ret_valid;
  logic [WIDTH-1:0] ret_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    occupancy;
  logic [CW-1:0]    inflight;
  logic             err;

  // Producer / pipe / consumer side
  modport master (
    output issue, ret_valid, ret_data, out_ready,
    input  can_issue, out_valid, out_data, occupancy, inflight, err
  );

  // Return buffer side
  modport slave (
    input  issue, ret_valid, ret_data, out_ready,
    output can_issue, out_valid, out_data, occupancy, inflight, err
  );
endinterface

// File: rtl/latency_return_buffer.sv
// Buffers results leaving a fixed-latency pipe and issues credits so nothing launched can overflow.
// Latency: a result returned in cycle N is at the FIFO head in cycle N+1 (no bypass).
// Backpressure: consumer stalls via out_ready; producer is held off by can_issue (space incl. in-flight).
module latency_return_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  latency_return_buffer_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [CW:0]   FULL_EXT = (CW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    occ;
  logic [CW-1:0]    infl;
  logic             err_q;

  logic             pop;
  logic             push;
  logic             ret_ok;
  logic             ret_orphan;
  logic             push_over;
  logic             issue_over;
  logic [CW:0]      committed;

  // Credits are computed only from registered counts; a pop this cycle frees
  // a credit next cycle, which keeps can_issue off the out_ready path.
  assign committed     = {1'b0, occ} + {1'b0, infl};
  assign bus.can_issue = committed < FULL_EXT;

  assign bus.out_valid = (occ != '0);
  assign bus.out_data  = mem[rd_ptr];
  assign bus.occupancy = occ;
  assign bus.inflight  = infl;
  assign bus.err       = err_q;

  assign pop        = bus.out_valid & bus.out_ready;
  // A return with nothing outstanding cannot belong to us: drop it.
  assign ret_orphan = bus.ret_valid & (infl == '0);
  assign ret_ok     = bus.ret_valid & ~ret_orphan;
  // A genuine return that finds the buffer full (only after an illegal issue) is lost.
  assign push_over  = ret_ok & (occ == FULL) & ~pop;
  assign push       = ret_ok & ~push_over;
  assign issue_over = bus.issue & ~bus.can_issue;

  // In-flight count: issue adds, a genuine return removes; saturates at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      infl <= '0;
    end else begin
      unique case ({bus.issue, ret_ok})
        2'b10:   if (infl != FULL) infl <= infl + CW'(1);
        2'b01:   infl <= infl - CW'(1);
        default: infl <= infl;
      endcase
    end
  end

  // Occupancy and pointers; DEPTH is a power of two so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage array, deliberately unreset: contents are only observed when out_valid=1.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.ret_data;
  end

  // Sticky protocol-violation flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (issue_over | ret_orphan | push_over) begin
      err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_latency_return_buffer.sv
// Bench: latency-2 delay pipe model in front of the buffer, scoreboard on the consumer side.
// Inputs are driven and outputs sampled on the falling clock edge.
// Multi-cycle sequences cover fill/drain, near-full push+pop, violations and mid-run reset.
module tb_latency_return_buffer;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  latency_return_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  latency_return_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- delay pipe model (latency 2) ----------------
  logic             p1_v, p2_v;
  logic [WIDTH-1:0] p1_d, p2_d;
  logic [WIDTH-1:0] iss_data;
  logic             inj_v;
  logic [WIDTH-1:0] inj_d;

  always @(posedge clk) begin
    if (rst) begin
      p1_v <= 1'b0;
      p2_v <= 1'b0;
    end else begin
      p1_v <= bus.issue;
      p1_d <= iss_data;
      p2_v <= p1_v;
      p2_d <= p1_d;
    end
  end

  assign bus.ret_valid = p2_v | inj_v;
  assign bus.ret_data  = inj_v ? inj_d : p2_d;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [WIDTH-1:0] data;
    int               cyc;
    bit               lat;
  } sb_t;
  sb_t sb[$];

  int tests = 0;
  int fails = 0;
  int pops = 0;
  int n_issued = 0;
  bit lat_chk = 0;
  logic [WIDTH-1:0] nextd;
  logic [WIDTH-1:0] last_pop;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of compliant producer/consumer activity (call just after a negedge).
  task automatic apply(input logic iss, input logic rdy);
    sb_t e;
    bus.out_ready = rdy;
    bus.issue     = iss & bus.can_issue;
    iss_data      = nextd;
    if (bus.issue) begin
      sb.push_back('{nextd, cyc, lat_chk});
      nextd = nextd + 1;
      n_issued++;
    end
    if (bus.out_valid && rdy) begin
      pops++;
      if (sb.size() == 0) begin
        check("pop_without_expected", 1, 0);
      end else begin
        e = sb.pop_front();
        check("pop_data", bus.out_data, e.data);
        if (e.lat) check("issue_to_out_latency", cyc - e.cyc, 3);
        last_pop = bus.out_data;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.issue = 1'b0;
    bus.out_ready = 1'b0;
    inj_v = 1'b0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- fill/drain vector table ----------------
  typedef struct {
    logic       iss;
    logic       rdy;
    logic       e_can;
    logic [2:0] e_occ;
    logic [2:0] e_inf;
    logic       e_ov;
  } vec_t;
  vec_t vt[12];

  initial begin
    // state expected at the start of each cycle, then the inputs for that cycle
    vt[0]  = '{1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 3'd0, 3'd1, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 3'd0, 3'd2, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 1'b1, 3'd1, 3'd2, 1'b1};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 3'd2, 3'd2, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 3'd3, 3'd1, 1'b1};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 3'd4, 3'd0, 1'b1};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 3'd4, 3'd0, 1'b1};
    vt[8]  = '{1'b0, 1'b1, 1'b1, 3'd3, 3'd0, 1'b1};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 3'd2, 3'd0, 1'b1};
    vt[10] = '{1'b0, 1'b1, 1'b1, 3'd1, 3'd0, 1'b1};
    vt[11] = '{1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0};

    rst = 1'b1;
    bus.issue = 1'b0;
    bus.out_ready = 1'b0;
    inj_v = 1'b0;
    inj_d = '0;
    iss_data = '0;
    nextd = '0;
    last_pop = '0;

    // ---- 1: reset then idle ----
    do_reset();
    @(negedge clk);
    apply(1'b0, 1'b0);
    @(negedge clk);
    check("t1_occupancy", bus.occupancy, 0);
    check("t1_inflight", bus.inflight, 0);
    check("t1_out_valid", bus.out_valid, 0);
    check("t1_can_issue", bus.can_issue, 1);
    check("t1_err", bus.err, 0);

    // ---- 2: streaming, out_ready held high ----
    do_reset();
    nextd = 32'd0;
    lat_chk = 1'b1;
    begin
      int p0;
      p0 = pops;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        check($sformatf("t2_can_issue[%0d]", i), bus.can_issue, 1);
        apply(1'b1, 1'b1);
      end
      for (int n = 0; n < 10; n++) begin
        @(negedge clk);
        if (sb.size() == 0) break;
        apply(1'b0, 1'b1);
      end
      check("t2_all_drained", sb.size(), 0);
      check("t2_pop_count", pops - p0, 20);
      check("t2_err", bus.err, 0);
    end
    lat_chk = 1'b0;

    // ---- 3: stalled consumer, credit limit, drain (table driven) ----
    do_reset();
    nextd = 32'd200;
    n_issued = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("t3_can_issue[%0d]", i), bus.can_issue, vt[i].e_can);
      check($sformatf("t3_occupancy[%0d]", i), bus.occupancy, vt[i].e_occ);
      check($sformatf("t3_inflight[%0d]", i), bus.inflight, vt[i].e_inf);
      check($sformatf("t3_out_valid[%0d]", i), bus.out_valid, vt[i].e_ov);
      apply(vt[i].iss, vt[i].rdy);
    end
    check("t3_issues_accepted", n_issued, 4);
    check("t3_drained", sb.size(), 0);
    check("t3_err", bus.err, 0);

    // ---- 4: full, then simultaneous push and pop near full with pointer wrap ----
    do_reset();
    nextd = 32'd100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      apply(1'b1, 1'b0);
    end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.occupancy == 3'd4) break;
      apply(1'b0, 1'b0);
    end
    check("t4_full_occ", bus.occupancy, 4);
    check("t4_full_inflight", bus.inflight, 0);
    check("t4_full_can_issue", bus.can_issue, 0);
    apply(1'b0, 1'b1);
    @(negedge clk);
    check("t4_after_pop_occ", bus.occupancy, 3);
    check("t4_after_pop_can", bus.can_issue, 1);
    apply(1'b1, 1'b0);
    @(negedge clk);
    check("t4_issued_inflight", bus.inflight, 1);
    check("t4_issued_can", bus.can_issue, 0);
    apply(1'b0, 1'b0);
    @(negedge clk);
    check("t4_ret_occ", bus.occupancy, 3);
    apply(1'b0, 1'b1);
    @(negedge clk);
    check("t4_pushpop_occ", bus.occupancy, 3);
    check("t4_pushpop_inflight", bus.inflight, 0);
    check("t4_pushpop_err", bus.err, 0);
    for (int n = 0; n < 10 && bus.out_valid; n++) begin
      apply(1'b0, 1'b1);
      @(negedge clk);
    end
    check("t4_drained_sb", sb.size(), 0);
    check("t4_drained_occ", bus.occupancy, 0);
    check("t4_last_value", last_pop, 32'd104);

    // ---- 5a: issue while can_issue=0 ----
    do_reset();
    nextd = 32'd400;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      apply(1'b1, 1'b0);
    end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.occupancy == 3'd4) break;
      apply(1'b0, 1'b0);
    end
    check("t5a_can_issue_low", bus.can_issue, 0);
    check("t5a_err_before", bus.err, 0);
    bus.issue = 1'b1;
    @(negedge clk);
    bus.issue = 1'b0;
    check("t5a_err", bus.err, 1);
    check("t5a_inflight_incr", bus.inflight, 1);
    @(negedge clk);
    @(negedge clk);
    check("t5a_err_sticky", bus.err, 1);
    check("t5a_occ_unchanged", bus.occupancy, 4);

    // ---- 5b: return with nothing in flight ----
    do_reset();
    @(negedge clk);
    check("t5b_err_before", bus.err, 0);
    inj_d = 32'hDEADBEEF;
    inj_v = 1'b1;
    @(negedge clk);
    inj_v = 1'b0;
    check("t5b_err", bus.err, 1);
    check("t5b_occ", bus.occupancy, 0);
    check("t5b_inflight", bus.inflight, 0);
    check("t5b_out_valid", bus.out_valid, 0);

    // ---- 6: reset with occupancy=3, inflight=1 ----
    do_reset();
    nextd = 32'd300;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      apply(1'b1, 1'b0);
    end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.occupancy == 3'd3) break;
      apply(1'b0, 1'b0);
    end
    check("t6_pre_occ", bus.occupancy, 3);
    check("t6_pre_inflight", bus.inflight, 1);
    rst = 1'b1;
    bus.issue = 1'b0;
    bus.out_ready = 1'b0;
    sb.delete();
    @(negedge clk);
    check("t6_rst_occ", bus.occupancy, 0);
    check("t6_rst_inflight", bus.inflight, 0);
    check("t6_rst_out_valid", bus.out_valid, 0);
    check("t6_rst_can_issue", bus.can_issue, 1);
    rst = 1'b0;
    @(negedge clk);
    begin
      int p0;
      p0 = pops;
      nextd = 32'hA5A5A5A5;
      apply(1'b1, 1'b1);
      for (int n = 0; n < 10; n++) begin
        @(negedge clk);
        apply(1'b0, 1'b1);
        if (pops != p0) break;
      end
      check("t6_delivered", pops - p0, 1);
      check("t6_value", last_pop, 32'hA5A5A5A5);
      check("t6_err", bus.err, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
    $fatal(1);
  end
endmodule
